// File: rtl/au_sar_sgn.sv
// au_sar_sgn: successive-approximation search for a signed target held by an
// external comparator. The search runs in offset-binary (u) so that plain
// unsigned bit-by-bit approximation yields the two's-complement answer once
// the MSB is inverted.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a search (only honoured in IDLE)
//   abort              cancel an active search (WAIT only, beats cmp_valid)
//   trial[W]           candidate presented to the comparator
//   trial_valid        trial is stable and awaits a comparison result
//   cmp_valid          comparator result present for the current trial
//   cmp_lt, cmp_eq     target < trial, target == trial (cmp_eq has priority)
//   busy               search in progress
//   done               one-cycle completion pulse
//   result[W], exact   last completed result and whether cmp_eq confirmed it
module au_sar_sgn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] trial,
  output logic             trial_valid,
  input  logic             cmp_valid,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact
);
  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q, exact_d;

  logic [WIDTH-1:0] u_upd;
  logic [KW-1:0]    km1;

  assign km1 = k_q - KW'(1);

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    k_d      = k_q;
    trial_d  = trial_q;
    result_d = result_q;
    exact_d  = exact_q;
    u_upd    = u_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          u_d     = {1'b1, {(WIDTH-1){1'b0}}};
          k_d     = KW'(WIDTH-1);
          trial_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cmp_valid) begin
          if (cmp_eq) begin
            result_d = trial_q;
            exact_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            // target below trial: this bit overshoots, drop it
            if (cmp_lt) u_upd[k_q] = 1'b0;
            if (k_q != '0) begin
              u_upd[km1] = 1'b1;
              u_d        = u_upd;
              k_d        = km1;
              trial_d    = {~u_upd[WIDTH-1], u_upd[WIDTH-2:0]};
            end else begin
              // last bit resolved: trial keeps the final candidate shown
              u_d      = u_upd;
              result_d = {~u_upd[WIDTH-1], u_upd[WIDTH-2:0]};
              exact_d  = 1'b0;
              state_d  = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      u_q      <= '0;
      k_q      <= '0;
      trial_q  <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      k_q      <= k_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      exact_q  <= exact_d;
    end
  end

  assign trial       = trial_q;
  assign trial_valid = (state_q == S_WAIT);
  assign busy        = (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign exact       = exact_q;
endmodule

// File: tb/tb_au_sar_sgn.sv
module tb_au_sar_sgn;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, cmp_valid = 1'b0;
  logic cmp_lt, cmp_eq;
  logic signed [7:0] trial, result;
  logic trial_valid, busy, done, exact;

  int checks = 0, errors = 0, stab_err = 0;
  int tgt2_r = 0;  // target scaled by two, so half-integers are expressible
  logic signed [7:0] trials_q[$];

  au_sar_sgn #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .trial(trial), .trial_valid(trial_valid), .cmp_valid(cmp_valid),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .busy(busy), .done(done),
    .result(result), .exact(exact)
  );

  always #5 clk = ~clk;

  // behavioural signed comparator
  always_comb begin
    cmp_eq = (2 * int'(trial) == tgt2_r);
    cmp_lt = (tgt2_r < 2 * int'(trial));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one search; comparator answers after 0..maxlat waiting cycles.
  task automatic run(input int tgt2, input int maxlat, output int n,
                     output int dcyc, output logic signed [7:0] last_tr);
    int w;
    bit pend;
    logic signed [7:0] held;
    tgt2_r = tgt2; n = 0; dcyc = -1; pend = 0; held = '0; last_tr = '0;
    trials_q.delete();
    w = $urandom_range(0, maxlat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (done) begin dcyc = cyc; break; end
      if (trial_valid) begin
        if (pend && trial !== held) stab_err++;
        held = trial; pend = 1;
        if (w == 0) begin
          cmp_valid = 1'b1; n++; last_tr = trial; trials_q.push_back(trial);
          pend = 0; w = $urandom_range(0, maxlat);
        end else begin
          cmp_valid = 1'b0; w--;
        end
      end else cmp_valid = 1'b0;
      @(negedge clk);
    end
    cmp_valid = 1'b0;
  endtask

  typedef struct {
    int tgt2; int n; int res; bit ex; int last;
  } vec_t;
  vec_t vt[8];

  initial begin
    int n, dc;
    logic signed [7:0] lt;
    int exp37[8];
    vt[0] = '{74,   8,   37, 1,   37};
    vt[1] = '{0,    1,    0, 1,    0};
    vt[2] = '{-256, 8, -128, 0, -127};
    vt[3] = '{254,  8,  127, 1,  127};
    vt[4] = '{75,   8,   37, 0,   37};
    vt[5] = '{-2,   8,   -1, 1,   -1};
    vt[6] = '{128,  2,   64, 1,   64};
    vt[7] = '{-128, 2,  -64, 1,  -64};
    exp37 = '{0, 64, 32, 48, 40, 36, 38, 37};

    // reset state
    #3;
    chk("rst_trial", int'(trial), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", {busy, trial_valid, done, exact}, 0);
    @(negedge clk); rst_n = 1'b1;

    // spurious cmp_valid in IDLE must not start or complete anything
    cmp_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_idle", {busy, done}, 0);
    cmp_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(vt[i].tgt2, 0, n, dc, lt);
      chk($sformatf("v%0d_n", i), n, vt[i].n);
      chk($sformatf("v%0d_done_cyc", i), dc, vt[i].n + 1);
      chk($sformatf("v%0d_result", i), int'(result), vt[i].res);
      chk($sformatf("v%0d_exact", i), int'(exact), int'(vt[i].ex));
      chk($sformatf("v%0d_last_trial", i), int'(lt), vt[i].last);
      chk($sformatf("v%0d_trial_in_done", i), int'(trial), vt[i].last);
      if (i == 0)
        for (int j = 0; j < 8; j++)
          chk($sformatf("t37_trial%0d", j),
              (j < trials_q.size()) ? int'(trials_q[j]) : 999, exp37[j]);
      @(negedge clk);
      chk($sformatf("v%0d_after_done", i), {busy, done}, 0);
    end

    // randomised latency, spurious cmp_valid while idle between runs
    for (int i = 0; i < 8; i++) begin
      cmp_valid = 1'b1; @(negedge clk); cmp_valid = 1'b0;
      run(vt[i].tgt2, 5, n, dc, lt);
      chk($sformatf("r%0d_n", i), n, vt[i].n);
      chk($sformatf("r%0d_result", i), int'(result), vt[i].res);
      chk($sformatf("r%0d_exact", i), int'(exact), int'(vt[i].ex));
    end
    chk("trial_stable", stab_err, 0);

    // abort after the 3rd comparison (abort beats a simultaneous cmp_valid)
    @(negedge clk);
    tgt2_r = 74; n = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && !abort; c++) begin
      if (trial_valid) begin
        if (n == 3) abort = 1'b1;
        else n++;
        cmp_valid = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0; cmp_valid = 1'b0;
    chk("abort_busy", int'(busy), 0);
    dc = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dc++;
      @(negedge clk);
    end
    chk("abort_no_done", dc + int'(done), 0);
    chk("abort_result_held", int'(result), -64);
    chk("abort_exact_held", int'(exact), 1);
    run(10, 0, n, dc, lt);
    chk("post_abort_result", int'(result), 5);
    chk("post_abort_exact", int'(exact), 1);

    // asynchronous reset mid-search
    @(negedge clk);
    tgt2_r = 74;
    start = 1'b1; @(negedge clk); start = 1'b0;
    cmp_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_trial", int'(trial), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_flags", {busy, trial_valid, done, exact}, 0);
    cmp_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, done}, 0);
    run(74, 0, n, dc, lt);
    chk("post_rst_result", int'(result), 37);
    chk("post_rst_n", n, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/au_sar_sgn.md
AU_SAR_SGN -- requirements
Module: AU_sar_sgn

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length of the signed search value (>= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, begin a search; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, synchronous cancel of an active search.
REQ-006 SHALL have port trial, output, WIDTH, two's-complement candidate driven to the external signed comparator.
REQ-007 SHALL have port trial_valid, output, 1, trial is stable and awaits a comparison result.
REQ-008 SHALL have port cmp_valid, input, 1, comparison result for the current trial is present.
REQ-009 SHALL have port cmp_lt, input, 1, target < trial (signed).
REQ-010 SHALL have port cmp_eq, input, 1, target == trial.
REQ-011 SHALL have port busy, output, 1, search in progress.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port result, output, WIDTH, signed search result, held until the next completion.
REQ-014 SHALL have port exact, output, 1, result was confirmed by cmp_eq.

Function
REQ-015 SHALL implement states IDLE, WAIT, DONE; busy = (state == WAIT); trial_valid = (state == WAIT).
REQ-016 SHALL search in offset-binary form: u register; trial = u with MSB inverted; bit index k counts WIDTH-1 down to 0.
REQ-017 IDLE with start=1 at an edge SHALL load u = 1 << (WIDTH-1) (trial = 0), k = WIDTH-1, and enter WAIT.
REQ-018 In WAIT, a result SHALL be accepted only at an edge where cmp_valid=1; cmp_valid while not in WAIT SHALL be ignored.
REQ-019 Accepted cmp_eq=1 (cmp_eq has priority over cmp_lt) SHALL set result = trial, exact = 1, and enter DONE.
REQ-020 Accepted cmp_eq=0, cmp_lt=1 SHALL clear u[k]; cmp_eq=0, cmp_lt=0 SHALL keep u[k].
REQ-021 After REQ-020 with k > 0, SHALL set u[k-1], decrement k, and remain in WAIT.
REQ-022 After REQ-020 with k == 0, SHALL set result = updated u with MSB inverted (greatest value <= target), exact = 0, and enter DONE.
REQ-023 trial SHALL change only at accepting edges and SHALL be stable while waiting; comparator latency is unbounded.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-025 start while in WAIT or DONE SHALL be ignored.
REQ-026 abort=1 in WAIT SHALL return to IDLE at that edge, with no done pulse, result/exact unchanged; abort has priority over cmp_valid; abort in IDLE or DONE SHALL have no effect.
REQ-027 A search SHALL take at most WIDTH accepted comparisons; with a zero-latency comparator, start sampled at edge 0 gives trial_valid in cycles 1..n and done in cycle n+1, where n = number of comparisons.
REQ-028 trial SHALL hold its last value in IDLE and DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and u, k, trial, result, exact, done, busy, trial_valid all to 0, regardless of clk.
REQ-030 rst_n deasserted mid-search SHALL leave the block in IDLE with no done pulse; the next start SHALL begin a fresh search.

Verification (WIDTH=8, behavioural comparator model with zero latency unless stated)
REQ-031 Target 37 SHALL produce trials 0, 64, 32, 48, 40, 36, 38, 37, then done with result=37 and exact=1.
REQ-032 Target 0 SHALL produce one comparison, with done in cycle 2, result=0, and exact=1.
REQ-033 Target -128 SHALL produce eight lt responses, with final trial -127, result=-128, and exact=0; target 127 SHALL produce result=127 and exact=1.
REQ-034 A non-integer target 37.5 (model returns gt for 37) SHALL give result=37 and exact=0.
REQ-035 With comparator latency randomised 0-5 cycles plus spurious cmp_valid in IDLE, trial SHALL be stable while awaiting a result, and results SHALL match the zero-latency run.
REQ-036 abort asserted after the 3rd comparison SHALL cause no done pulse, leave result holding the previous value, and a subsequent start SHALL search correctly; rst_n pulsed mid-search SHALL make all outputs 0 asynchronously.
